// File: rtl/kbd_pkg.sv
// Shared types and widths for the matrix keypad scanner.
package kbd_pkg;

    localparam int DEFAULT_COLS = 4;
    localparam int DEFAULT_ROWS = 4;

    // Width of a key code for the default 4x4 keypad.
    localparam int KEY_W = $clog2(DEFAULT_COLS * DEFAULT_ROWS);

    // Debounce state machine states.
    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        HELD,
        RELEASE
    } kbd_state_t;

    // Outcome of one full-frame evaluation.
    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } eval_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs such as keypad rows.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Scans an active-low keypad column by column, snapshots each frame, debounces
// across frames and reports one key code per confirmed press and release.
// DEBOUNCE_FRAMES is expected to be >= 2 and SCAN_DIV >= 3 (synchronizer delay).
module matrix_keypad_scanner
    import kbd_pkg::*;
#(
    parameter int NUM_COLS        = 4,
    parameter int NUM_ROWS        = 4,
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_ROWS-1:0]                   row_sense,
    output logic [NUM_COLS-1:0]                   col_drive,
    output logic [$clog2(NUM_COLS*NUM_ROWS)-1:0]  key_code,
    output logic                                  key_valid,
    output logic                                  key_held,
    output logic                                  key_release,
    output logic                                  multi_key
);

    localparam int KW     = $clog2(NUM_COLS * NUM_ROWS);
    localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int DW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int CLOSED_W = $clog2(NUM_COLS * NUM_ROWS + 1);

    // ---------------------------------------------------------------
    // Row synchronizer: idle rows read high, so reset to all ones.
    // ---------------------------------------------------------------
    logic [NUM_ROWS-1:0] row_sync;

    sync_2ff #(
        .WIDTH     (NUM_ROWS),
        .RESET_VAL ({NUM_ROWS{1'b1}})
    ) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d     (row_sense),
        .q     (row_sync)
    );

    // ---------------------------------------------------------------
    // Column scanner
    // ---------------------------------------------------------------
    logic [DW-1:0]       dwell_reg;
    logic [COL_W-1:0]    col_idx_reg;
    logic [COL_W-1:0]    col_idx_next;
    logic [NUM_COLS-1:0] col_drive_reg;
    logic                term;
    logic                frame_eval;

    assign term         = (dwell_reg == DW'(SCAN_DIV - 1));
    assign frame_eval   = term && (col_idx_reg == COL_W'(NUM_COLS - 1));
    assign col_idx_next = (col_idx_reg == COL_W'(NUM_COLS - 1)) ? '0 : col_idx_reg + COL_W'(1);

    // Dwell on each column for SCAN_DIV cycles, then drive the next one low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dwell_reg     <= '0;
            col_idx_reg   <= '0;
            col_drive_reg <= ~NUM_COLS'(1);
        end else if (term) begin
            dwell_reg     <= '0;
            col_idx_reg   <= col_idx_next;
            col_drive_reg <= ~(NUM_COLS'(1) << col_idx_next);
        end else begin
            dwell_reg     <= dwell_reg + DW'(1);
        end
    end

    assign col_drive = col_drive_reg;

    // ---------------------------------------------------------------
    // Frame snapshot: one row register per column, loaded on that
    // column's terminal dwell count.
    // ---------------------------------------------------------------
    logic [NUM_COLS*NUM_ROWS-1:0] snapshot_flat;

    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_snap
            logic [NUM_ROWS-1:0] col_snap_reg;

            // Capture this column's synchronized rows at the end of its dwell.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    col_snap_reg <= '1;
                end else if (term && (col_idx_reg == COL_W'(gi))) begin
                    col_snap_reg <= row_sync;
                end
            end

            assign snapshot_flat[gi*NUM_ROWS +: NUM_ROWS] = col_snap_reg;
        end
    endgenerate

    // ---------------------------------------------------------------
    // Frame evaluation. The last column is still being captured on the
    // evaluation cycle, so its live synchronized rows stand in for it.
    // ---------------------------------------------------------------
    logic [CLOSED_W-1:0] closed_count;
    logic [KW-1:0]       eval_code;
    eval_t               eval_result;

    // Count closed keys in the frame and remember the code of the last one found.
    always_comb begin
        closed_count = '0;
        eval_code    = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if ((int'(col_idx_reg) == c) ? !row_sync[r] : !snapshot_flat[c*NUM_ROWS + r]) begin
                    closed_count = closed_count + CLOSED_W'(1);
                    eval_code    = KW'(c * NUM_ROWS + r);
                end
            end
        end
        if (closed_count == '0) begin
            eval_result = NONE;
        end else if (closed_count == CLOSED_W'(1)) begin
            eval_result = SINGLE;
        end else begin
            eval_result = MULTI;
        end
    end

    // ---------------------------------------------------------------
    // Debounce FSM
    // ---------------------------------------------------------------
    kbd_state_t     state_reg,       state_next;
    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [KW-1:0]  cand_reg,        cand_next;
    logic [KW-1:0]  key_code_reg,    key_code_next;
    logic           key_valid_reg,   key_valid_next;
    logic           key_held_reg,    key_held_next;
    logic           key_release_reg, key_release_next;
    logic           multi_key_reg,   multi_key_next;

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            cand_reg        <= '0;
            key_code_reg    <= '0;
            key_valid_reg   <= 1'b0;
            key_held_reg    <= 1'b0;
            key_release_reg <= 1'b0;
            multi_key_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            cand_reg        <= cand_next;
            key_code_reg    <= key_code_next;
            key_valid_reg   <= key_valid_next;
            key_held_reg    <= key_held_next;
            key_release_reg <= key_release_next;
            multi_key_reg   <= multi_key_next;
        end
    end

    // Next-state logic; transitions only on frame evaluation cycles.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        cand_next        = cand_reg;
        key_code_next    = key_code_reg;
        key_valid_next   = 1'b0;
        key_held_next    = key_held_reg;
        key_release_next = 1'b0;
        multi_key_next   = multi_key_reg;
        cnt_inc          = (cnt_reg >= CNT_W'(DEBOUNCE_FRAMES)) ? cnt_reg : cnt_reg + CNT_W'(1);

        if (frame_eval) begin
            multi_key_next = (eval_result == MULTI);
            unique case (state_reg)
                IDLE: begin
                    if (eval_result == SINGLE) begin
                        state_next = CONFIRM;
                        cand_next  = eval_code;
                        cnt_next   = CNT_W'(1);
                    end
                end
                CONFIRM: begin
                    if (eval_result == SINGLE && eval_code == cand_reg) begin
                        if (cnt_inc >= CNT_W'(DEBOUNCE_FRAMES)) begin
                            state_next     = HELD;
                            cnt_next       = '0;
                            key_code_next  = cand_reg;
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else if (eval_result == SINGLE) begin
                        // A different key took over: start counting it afresh.
                        cand_next = eval_code;
                        cnt_next  = CNT_W'(1);
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                HELD: begin
                    // Rollover and extra keys are ignored while a key is held.
                    if (eval_result == NONE) begin
                        state_next = RELEASE;
                        cnt_next   = CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (eval_result == NONE) begin
                        if (cnt_inc >= CNT_W'(DEBOUNCE_FRAMES)) begin
                            state_next       = IDLE;
                            cnt_next         = '0;
                            key_held_next    = 1'b0;
                            key_release_next = 1'b1;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        // Bounce during release: fall back to held, no new press.
                        state_next = HELD;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign key_code    = key_code_reg;
    assign key_valid   = key_valid_reg;
    assign key_held    = key_held_reg;
    assign key_release = key_release_reg;
    assign multi_key   = multi_key_reg;

endmodule

// File: doc/matrix_keypad_scanner.md
Name: matrix_keypad_scanner

Overview:
- Input-side counterpart to the LED matrix column scanner. The display scanner drives rows and columns out; this block drives keypad columns and reads rows back.
- Scans a 4x4 active-low keypad one column at a time, builds a frame snapshot, debounces across frames, and reports one key code per confirmed press.
- Feeds operator commands (manual irrigation, clean, mode select) into the irrigation control MEFs. Runs off a divided clock from the existing clock_divisor chain.

Parameters:
- NUM_COLS, 4, number of keypad columns driven.
- NUM_ROWS, 4, number of keypad rows sensed.
- SCAN_DIV, 4, clock cycles each column is driven; must be >= 3 to cover the 2-flop synchronizer.
- DEBOUNCE_FRAMES, 3, consecutive identical frames required to accept a press or a release.

Ports:
- clock  input  1  block clock.
- reset  input  1  asynchronous, active-low reset.
- row_sense  input  NUM_ROWS  keypad rows; pulled up externally; 0 = key closed on the driven column.
- col_drive  output  NUM_COLS  one-hot-low column drive.
- key_code  output  clog2(NUM_COLS*NUM_ROWS)  code of the last accepted key = col*NUM_ROWS + row.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  level; high from acceptance until the release is accepted.
- key_release  output  1  one-cycle pulse when the release is accepted.
- multi_key  output  1  level; high for the frame after an evaluation that found more than one closed key.

Behaviour:
- Reset (reset=0, async): col_idx=0, col_drive=1110, dwell counter=0, frame snapshot cleared, state=IDLE, debounce count=0. key_code=0, key_valid=0, key_held=0, key_release=0, multi_key=0.
- row_sense passes through a 2-flop synchronizer before use.
- Dwell counter runs 0..SCAN_DIV-1. On the terminal count:
  - store the synchronized row bits into snapshot[col_idx];
  - advance col_idx, wrapping from NUM_COLS-1 to 0;
  - col_drive = ~(1<<col_idx) in the next cycle.
- Scanning never stops, in every state.
- Frame evaluation happens on the terminal count of column NUM_COLS-1. A frame is NUM_COLS*SCAN_DIV cycles. The evaluation counts closed keys:
  - 0 closed -> NONE;
  - exactly 1 -> SINGLE(code);
  - more than 1 -> MULTI.
- multi_key is updated at every frame evaluation.
- FSM, transitions taken at frame evaluation only:
  - IDLE: SINGLE -> CONFIRM with cand=code, cnt=1. NONE/MULTI -> stay in IDLE.
  - CONFIRM: SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_FRAMES -> HELD, key_code=cand, key_valid=1 for one cycle, key_held=1. SINGLE(other) -> restart with cand=other, cnt=1. NONE/MULTI -> IDLE.
  - HELD: NONE -> RELEASE with cnt=1. SINGLE(any) or MULTI -> stay in HELD; rollover is ignored and key_code is unchanged.
  - RELEASE: NONE -> cnt+1. When cnt reaches DEBOUNCE_FRAMES -> IDLE, key_held=0, key_release=1 for one cycle. Any closed key -> HELD with cnt=0 and no new key_valid.
- Latency:
  - press stable from frame boundary k -> key_valid at the evaluation ending frame k+DEBOUNCE_FRAMES-1;
  - worst case (DEBOUNCE_FRAMES+1)*NUM_COLS*SCAN_DIV+2 cycles from the first stable edge.
- key_valid and key_release are never high in the same cycle.
- cnt saturates at DEBOUNCE_FRAMES.
- Reset mid-operation discards any pending candidate; no pulse is emitted.

Decomposition:
- Shared package kbd_pkg holds:
  - the state enum {IDLE, CONFIRM, HELD, RELEASE};
  - the evaluation result enum {NONE, SINGLE, MULTI};
  - KEY_W = clog2(NUM_COLS*NUM_ROWS).
- One sub-module: sync_2ff, a parameterized-width 2-flop synchronizer with async active-low reset, used for row_sense.

Test Plan:
All scenarios use the defaults: SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 cycles. The bench keypad model pulls row r low while col_drive[c]=0 and key (c,r) is closed.
- Assert reset=0 mid-clock -> col_drive=1110 immediately; key_code=0, key_valid=0, key_held=0, key_release=0, multi_key=0.
- Close key (col2,row1) for 6 frames -> exactly one key_valid pulse, key_code=9, key_held=1 within 4 frames of closure.
- Close (col2,row1) for 1 frame, then open -> no key_valid; state returns to IDLE; key_code stays 0.
- Close (col0,row0) and (col3,row3) together for 4 frames -> multi_key=1 after the first evaluation, no key_valid; multi_key=0 one frame after both open.
- After the (col2,row1) press is accepted: open for 2 frames, re-close, then open for 3 frames -> no key_release until the third consecutive open frame; then one key_release pulse, key_held=0, no second key_valid.
- Assert reset during CONFIRM (frame 2 of key (col1,row3)), release reset, keep the key closed -> scan restarts at col0 and key_valid with key_code=7 arrives a full 3 frames later.
